// File: rtl/spi_multi_ch_rx_if.sv
// SPI bus between an external master and the multi-channel receiver.
// Frame select is active high; MOSI and MISO are MSB first.
interface spi_multi_ch_rx_if;
  logic ss;
  logic mosi;
  logic miso;

  modport master (output ss, output mosi, input miso);
  modport slave  (input ss, input mosi, output miso);
endinterface

// File: rtl/spi_multi_ch_rx.sv
// SPI slave: {addr,data} frames into NUM_CH channel registers; result pulses one sck after the final bit; no backpressure (master-driven).
// Optional trailing even-parity bit on receive and echo when SPI_RX_PARITY_EN is defined.
module spi_multi_ch_rx #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4
) (
  input  logic                     sck,
  input  logic                     rst_n,
  spi_multi_ch_rx_if.slave         bus,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     frame_valid,
  output logic [ADDR_W-1:0]        frame_addr,
  output logic                     short_err,
  output logic                     addr_err,
  output logic                     parity_err
);

  localparam int FRAME_W = ADDR_W + DATA_W;
`ifdef SPI_RX_PARITY_EN
  localparam int LEN = FRAME_W + 1;
`else
  localparam int LEN = FRAME_W;
`endif
  localparam int CNT_W = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(LEN - 1);
  localparam logic [ADDR_W:0]   NUM_CH_L = (ADDR_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [LEN-2:0]    rx_shift;
  logic [LEN-1:0]    tx_shift;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_data;

  logic [LEN-1:0]    frame;
  logic [LEN-1:0]    echo;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_data;
  logic              addr_ok;

  // frame is the full word as it stands once the current mosi bit is taken
  assign frame   = {rx_shift, bus.mosi};
  assign f_addr  = frame[LEN-1 -: ADDR_W];
  assign f_data  = frame[LEN-1-ADDR_W -: DATA_W];
  assign addr_ok = {1'b0, f_addr} < NUM_CH_L;
  assign bus.miso = tx_shift[LEN-1];

`ifdef SPI_RX_PARITY_EN
  logic par_ok;
  assign par_ok = ~^frame;
  assign echo   = {last_addr, last_data, ^{last_addr, last_data}};
`else
  assign echo       = {last_addr, last_data};
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge sck) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      last_addr   <= '0;
      last_data   <= '0;
      ch_data     <= '0;
      frame_addr  <= '0;
      frame_valid <= 1'b0;
      short_err   <= 1'b0;
      addr_err    <= 1'b0;
`ifdef SPI_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      frame_valid <= 1'b0;
      short_err   <= 1'b0;
      addr_err    <= 1'b0;
`ifdef SPI_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.ss) begin
            rx_shift <= {{(LEN-2){1'b0}}, bus.mosi};
            bit_cnt  <= CNT_W'(1);
            tx_shift <= {tx_shift[LEN-2:0], 1'b0};
            state    <= SHIFT;
          end else begin
            bit_cnt  <= '0;
            tx_shift <= echo;
          end
        end
        SHIFT: begin
          if (!bus.ss) begin
            short_err <= 1'b1;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            state     <= IDLE;
          end else begin
            rx_shift <= frame[LEN-2:0];
            bit_cnt  <= bit_cnt + 1'b1;
            tx_shift <= {tx_shift[LEN-2:0], 1'b0};
            if (bit_cnt == LAST_IDX) begin
              state <= HOLD;
`ifdef SPI_RX_PARITY_EN
              if (!par_ok) parity_err <= 1'b1; else
`endif
              if (addr_ok) begin
                for (int k = 0; k < NUM_CH; k++) begin
                  if (f_addr == ADDR_W'(k)) ch_data[k*DATA_W +: DATA_W] <= f_data;
                end
                frame_addr  <= f_addr;
                last_addr   <= f_addr;
                last_data   <= f_data;
                frame_valid <= 1'b1;
              end else begin
                frame_addr <= f_addr;
                addr_err   <= 1'b1;
              end
            end
          end
        end
        HOLD: begin
          // over-clocked bits are dropped until the master releases ss
          if (!bus.ss) begin
            bit_cnt <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_multi_ch_rx.sv
// Scoreboarded bench for spi_multi_ch_rx: frames, errors, over-clocking, MISO echo, mid-frame reset.
module tb_spi_multi_ch_rx;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int NUM_CH = 4;
`ifdef SPI_RX_PARITY_EN
  localparam int LEN = 12;
`else
  localparam int LEN = 11;
`endif
  localparam logic [3:0] K_VALID = 4'b0001;
  localparam logic [3:0] K_AERR  = 4'b0010;
  localparam logic [3:0] K_SERR  = 4'b0100;
  localparam logic [3:0] K_PERR  = 4'b1000;

  typedef struct {
    logic [3:0] kind;
    logic [2:0] addr;
    logic [7:0] data;
  } ev_t;

  logic                     sck = 1'b0;
  logic                     rst_n;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic                     frame_valid;
  logic [ADDR_W-1:0]        frame_addr;
  logic                     short_err;
  logic                     addr_err;
  logic                     parity_err;

  spi_multi_ch_rx_if bus();

  spi_multi_ch_rx #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH)) dut (
    .sck         (sck),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .ch_data     (ch_data),
    .frame_valid (frame_valid),
    .frame_addr  (frame_addr),
    .short_err   (short_err),
    .addr_err    (addr_err),
    .parity_err  (parity_err)
  );

  always #5 sck = ~sck;

  int vectors = 0;
  int miscompares = 0;
  ev_t exp_q[$];
  logic [31:0] m_ch;
  logic [2:0]  m_addr;
  logic [2:0]  m_last_a;
  logic [7:0]  m_last_d;

  function automatic logic [15:0] mk(input logic [2:0] a, input logic [7:0] d);
    logic [10:0] p = {a, d};
`ifdef SPI_RX_PARITY_EN
    return {4'b0, p, ^p};
`else
    return {5'b0, p};
`endif
  endfunction

  function automatic logic [15:0] echo_exp();
    logic [10:0] p = {m_last_a, m_last_d};
`ifdef SPI_RX_PARITY_EN
    return {4'b0, p, ^p};
`else
    return {5'b0, p};
`endif
  endfunction

  task automatic model_commit(input logic [2:0] a, input logic [7:0] d);
    m_ch[a*8 +: 8] = d;
    m_addr   = a;
    m_last_a = a;
    m_last_d = d;
  endtask

  // n data edges, then extra edges with ss still high, then ss low for a few edges
  task automatic send(input logic [15:0] f, input int n, input int extra, output logic [15:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge sck);
      cap = {cap[14:0], bus.miso};
      bus.ss   = 1'b1;
      bus.mosi = f[LEN-1-i];
    end
    for (int i = 0; i < extra; i++) begin
      @(negedge sck);
      bus.mosi = 1'($urandom_range(0, 1));
    end
    @(negedge sck);
    bus.ss   = 1'b0;
    bus.mosi = 1'b0;
    repeat (3) @(negedge sck);
  endtask

  // Scoreboard: every pulse must match the oldest expected event
  always @(negedge sck) begin
    ev_t ev;
    logic [3:0] got;
    got = {parity_err, short_err, addr_err, frame_valid};
    if (got != 4'b0) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse got=%b required=none", got);
      end else begin
        ev = exp_q.pop_front();
        if (got !== ev.kind) begin
          miscompares++;
          $display("FAIL pulse_kind got=%b required=%b", got, ev.kind);
        end
        vectors++;
        if (frame_addr !== ev.addr) begin
          miscompares++;
          $display("FAIL pulse_frame_addr got=%0d required=%0d", frame_addr, ev.addr);
        end
        if (ev.kind == K_VALID) begin
          vectors++;
          if (ch_data[ev.addr*8 +: 8] !== ev.data) begin
            miscompares++;
            $display("FAIL pulse_ch_data got=%h required=%h", ch_data[ev.addr*8 +: 8], ev.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    vectors++;
    if (ch_data !== 32'h0) begin
      miscompares++; $display("FAIL reset_ch_data got=%h required=0", ch_data);
    end
    vectors++;
    if (frame_addr !== 3'd0) begin
      miscompares++; $display("FAIL reset_frame_addr got=%0d required=0", frame_addr);
    end
    vectors++;
    if (bus.miso !== 1'b0) begin
      miscompares++; $display("FAIL reset_miso got=%b required=0", bus.miso);
    end
    vectors++;
    if ({parity_err, short_err, addr_err, frame_valid} !== 4'b0) begin
      miscompares++; $display("FAIL reset_pulses got=%b required=0000",
                              {parity_err, short_err, addr_err, frame_valid});
    end
  endtask

  task automatic test_commit();
    logic [15:0] cap, e;
    e = echo_exp();
    exp_q.push_back('{K_VALID, 3'd3, 8'hA5});
    send(mk(3'd3, 8'hA5), LEN, 0, cap);
    model_commit(3'd3, 8'hA5);
    vectors++;
    if (cap !== e) begin
      miscompares++; $display("FAIL commit_echo got=%h required=%h", cap, e);
    end
    vectors++;
    if (ch_data !== m_ch) begin
      miscompares++; $display("FAIL commit_ch_data got=%h required=%h", ch_data, m_ch);
    end
    vectors++;
    if (frame_addr !== 3'd3) begin
      miscompares++; $display("FAIL commit_frame_addr got=%0d required=3", frame_addr);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL commit_pending got=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_addr_err();
    logic [15:0] cap, e;
    e = echo_exp();
    exp_q.push_back('{K_AERR, 3'd5, 8'h3C});
    send(mk(3'd5, 8'h3C), LEN, 0, cap);
    m_addr = 3'd5;
    vectors++;
    if (cap !== e) begin
      miscompares++; $display("FAIL aerr_echo got=%h required=%h", cap, e);
    end
    vectors++;
    if (ch_data !== m_ch) begin
      miscompares++; $display("FAIL aerr_ch_data got=%h required=%h", ch_data, m_ch);
    end
    vectors++;
    if (frame_addr !== 3'd5) begin
      miscompares++; $display("FAIL aerr_frame_addr got=%0d required=5", frame_addr);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL aerr_pending got=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_short();
    logic [15:0] cap;
    exp_q.push_back('{K_SERR, m_addr, 8'h00});
    send(mk(3'd1, 8'hFF), 6, 0, cap);
    vectors++;
    if (ch_data !== m_ch) begin
      miscompares++; $display("FAIL short_ch_data got=%h required=%h", ch_data, m_ch);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL short_pending got=%0d required=0", exp_q.size());
    end
    exp_q.push_back('{K_VALID, 3'd1, 8'h11});
    send(mk(3'd1, 8'h11), LEN, 0, cap);
    model_commit(3'd1, 8'h11);
    vectors++;
    if (ch_data[15:8] !== 8'h11) begin
      miscompares++; $display("FAIL short_recover got=%h required=11", ch_data[15:8]);
    end
    vectors++;
    if (ch_data !== m_ch) begin
      miscompares++; $display("FAIL short_recover_all got=%h required=%h", ch_data, m_ch);
    end
  endtask

  task automatic test_overclock();
    logic [15:0] cap;
    exp_q.push_back('{K_VALID, 3'd2, 8'h77});
    send(mk(3'd2, 8'h77), LEN, 4, cap);
    model_commit(3'd2, 8'h77);
    vectors++;
    if (ch_data !== m_ch) begin
      miscompares++; $display("FAIL overclock_ch_data got=%h required=%h", ch_data, m_ch);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL overclock_pending got=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_echo();
    logic [15:0] cap, e;
    exp_q.push_back('{K_VALID, 3'd0, 8'h5A});
    send(mk(3'd0, 8'h5A), LEN, 0, cap);
    model_commit(3'd0, 8'h5A);
    e = echo_exp();
    exp_q.push_back('{K_VALID, 3'd1, 8'h22});
    send(mk(3'd1, 8'h22), LEN, 0, cap);
    vectors++;
    if (cap[LEN-1 -: 11] !== 11'b000_0101_1010) begin
      miscompares++; $display("FAIL echo_plan got=%b required=00001011010", cap[LEN-1 -: 11]);
    end
    vectors++;
    if (cap !== e) begin
      miscompares++; $display("FAIL echo_full got=%h required=%h", cap, e);
    end
    model_commit(3'd1, 8'h22);
    vectors++;
    if (ch_data !== m_ch) begin
      miscompares++; $display("FAIL echo_ch_data got=%h required=%h", ch_data, m_ch);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] cap, f;
    f = mk(3'd1, 8'h42);
    for (int i = 0; i < 5; i++) begin
      @(negedge sck);
      bus.ss   = 1'b1;
      bus.mosi = f[LEN-1-i];
    end
    @(negedge sck);
    rst_n  = 1'b0;
    bus.ss = 1'b0;
    repeat (2) @(negedge sck);
    vectors++;
    if (ch_data !== 32'h0) begin
      miscompares++; $display("FAIL midrst_ch_data got=%h required=0", ch_data);
    end
    vectors++;
    if (frame_addr !== 3'd0) begin
      miscompares++; $display("FAIL midrst_frame_addr got=%0d required=0", frame_addr);
    end
    vectors++;
    if (bus.miso !== 1'b0) begin
      miscompares++; $display("FAIL midrst_miso got=%b required=0", bus.miso);
    end
    rst_n = 1'b1;
    m_ch = '0; m_addr = '0; m_last_a = '0; m_last_d = '0;
    repeat (2) @(negedge sck);
    exp_q.push_back('{K_VALID, 3'd1, 8'h42});
    send(f, LEN, 0, cap);
    model_commit(3'd1, 8'h42);
    vectors++;
    if (cap !== 16'h0) begin
      miscompares++; $display("FAIL midrst_echo got=%h required=0", cap);
    end
    vectors++;
    if (ch_data !== m_ch) begin
      miscompares++; $display("FAIL midrst_commit got=%h required=%h", ch_data, m_ch);
    end
`ifdef SPI_RX_PARITY_EN
    exp_q.push_back('{K_PERR, m_addr, 8'h00});
    send(mk(3'd3, 8'h99) ^ 16'h0001, LEN, 0, cap);
    vectors++;
    if (ch_data !== m_ch) begin
      miscompares++; $display("FAIL parity_ch_data got=%h required=%h", ch_data, m_ch);
    end
    vectors++;
    if (frame_addr !== m_addr) begin
      miscompares++; $display("FAIL parity_frame_addr got=%0d required=%0d", frame_addr, m_addr);
    end
`endif
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL midrst_pending got=%0d required=0", exp_q.size());
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.ss   = 1'b0;
    bus.mosi = 1'b0;
    m_ch = '0; m_addr = '0; m_last_a = '0; m_last_d = '0;
    repeat (3) @(negedge sck);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge sck);
    test_commit();
    test_addr_err();
    test_short();
    test_overclock();
    test_echo();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
